// File: rtl/full_adder_pkg.sv
// Shared constants and a reference add for the full_adder family.
// Checkers call fa_ref to get {cout, sum} for any legal width.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    // Returns cout in bit 64 and the wrapped sum in bits [width-1:0].
    function automatic logic [64:0] fa_ref(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic        ci,
        input int unsigned width
    );
        logic [64:0] mask;
        logic [64:0] t;
        logic [64:0] r;
        if (width >= 64) begin
            mask = {1'b0, {64{1'b1}}};
        end else begin
            mask = (65'd1 << width) - 65'd1;
        end
        t = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, ci};
        r = t & mask;
        r[64] = t[width];
        return r;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell, purely combinational.
// Chained by full_adder to form a ripple-carry adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with optional output register.
// out_valid is always registered; sum/cout only when REG_OUT=1.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic             r_valid;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a  (x[i]),
            .b  (y[i]),
            .ci (w_c[i]),
            .s  (w_s[i]),
            .co (w_c[i+1])
        );
    end

    // Valid flag tracks in_valid one cycle late; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

    assign out_valid = r_valid;

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] r_sum;
        logic             r_cout;

        // Capture the result on valid input, otherwise hold it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sum  <= '0;
                r_cout <= 1'b0;
            end else if (in_valid) begin
                r_sum  <= w_s;
                r_cout <= w_c[WIDTH];
            end
        end

        assign sum  = r_sum;
        assign cout = r_cout;
    end else begin : g_comb
        assign sum  = w_s;
        assign cout = w_c[WIDTH];
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder across several widths.
// Expected values come from plain integer arithmetic.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // WIDTH=1 registered
    logic       a_v = 0, a_x = 0, a_y = 0, a_c = 0;
    logic       a_s, a_co, a_ov;
    // WIDTH=8 registered
    logic       b_v = 0, b_c = 0;
    logic [7:0] b_x = 0, b_y = 0, b_s;
    logic       b_co, b_ov;
    // WIDTH=4 combinational
    logic       d_v = 0, d_c = 0;
    logic [3:0] d_x = 0, d_y = 0, d_s;
    logic       d_co, d_ov;
    // WIDTH=16 registered, random
    logic        r_v = 0, r_c = 0, r_rst = 1;
    logic [15:0] r_x = 0, r_y = 0, r_s;
    logic        r_co, r_ov;

    full_adder #(.WIDTH(1), .REG_OUT(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(a_v), .x(a_x), .y(a_y),
        .cin(a_c), .sum(a_s), .cout(a_co), .out_valid(a_ov)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(b_v), .x(b_x), .y(b_y),
        .cin(b_c), .sum(b_s), .cout(b_co), .out_valid(b_ov)
    );

    full_adder #(.WIDTH(4), .REG_OUT(0)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(d_v), .x(d_x), .y(d_y),
        .cin(d_c), .sum(d_s), .cout(d_co), .out_valid(d_ov)
    );

    full_adder #(.WIDTH(16), .REG_OUT(1)) u_w16 (
        .clk(clk), .rst(r_rst), .in_valid(r_v), .x(r_x), .y(r_y),
        .cin(r_c), .sum(r_s), .cout(r_co), .out_valid(r_ov)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          e;
        logic [16:0] m_res;
        logic        m_v;

        // reset state
        rst = 1'b1;
        r_rst = 1'b1;
        tick();
        tick();
        chk("rst_w1_sum", 64'(a_s), 64'd0);
        chk("rst_w1_cout", 64'(a_co), 64'd0);
        chk("rst_w1_ov", 64'(a_ov), 64'd0);
        chk("rst_w8_sum", 64'(b_s), 64'd0);
        chk("rst_w16_ov", 64'(r_ov), 64'd0);
        rst = 1'b0;

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            a_v = 1'b1;
            a_x = (i & 4) != 0;
            a_y = (i & 2) != 0;
            a_c = (i & 1) != 0;
            tick();
            e = int'(a_x) + int'(a_y) + int'(a_c);
            chk($sformatf("w1_sum_%0d", i), 64'(a_s), 64'(e % 2));
            chk($sformatf("w1_cout_%0d", i), 64'(a_co), 64'(e / 2));
            chk($sformatf("w1_ov_%0d", i), 64'(a_ov), 64'd1);
        end

        // in_valid hold
        a_v = 1'b1; a_x = 1'b1; a_y = 1'b1; a_c = 1'b0;
        tick();
        chk("hold_load_sum", 64'(a_s), 64'd0);
        chk("hold_load_cout", 64'(a_co), 64'd1);
        a_v = 1'b0; a_x = 1'b0; a_y = 1'b0; a_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_sum_%0d", i), 64'(a_s), 64'd0);
            chk($sformatf("hold_cout_%0d", i), 64'(a_co), 64'd1);
            chk($sformatf("hold_ov_%0d", i), 64'(a_ov), 64'd0);
        end

        // reset mid-stream discards the captured input
        a_v = 1'b1; a_x = 1'b1; a_y = 1'b1; a_c = 1'b1;
        rst = 1'b1;
        tick();
        chk("midrst_sum", 64'(a_s), 64'd0);
        chk("midrst_cout", 64'(a_co), 64'd0);
        chk("midrst_ov", 64'(a_ov), 64'd0);
        rst = 1'b0;
        a_x = 1'b1; a_y = 1'b0; a_c = 1'b0;
        tick();
        chk("postrst_sum", 64'(a_s), 64'd1);
        chk("postrst_cout", 64'(a_co), 64'd0);
        chk("postrst_ov", 64'(a_ov), 64'd1);
        a_v = 1'b0;

        // WIDTH=8 boundary vectors
        b_v = 1'b1; b_x = 8'hFF; b_y = 8'h01; b_c = 1'b0;
        tick();
        chk("w8_ff01_sum", 64'(b_s), 64'h00);
        chk("w8_ff01_cout", 64'(b_co), 64'd1);
        b_x = 8'h7F; b_y = 8'h80; b_c = 1'b1;
        tick();
        chk("w8_7f80_sum", 64'(b_s), 64'h00);
        chk("w8_7f80_cout", 64'(b_co), 64'd1);
        b_x = 8'h12; b_y = 8'h34; b_c = 1'b1;
        tick();
        chk("w8_1234_sum", 64'(b_s), 64'h47);
        chk("w8_1234_cout", 64'(b_co), 64'd0);
        chk("w8_ov", 64'(b_ov), 64'd1);
        b_v = 1'b0;

        // WIDTH=4 combinational outputs
        d_v = 1'b0;
        tick();
        d_v = 1'b1; d_x = 4'hA; d_y = 4'h7; d_c = 1'b1;
        #1;
        chk("w4_sum_comb", 64'(d_s), 64'h2);
        chk("w4_cout_comb", 64'(d_co), 64'd1);
        chk("w4_ov_before", 64'(d_ov), 64'd0);
        tick();
        chk("w4_ov_after", 64'(d_ov), 64'd1);
        d_v = 1'b0;
        tick();
        chk("w4_ov_drop", 64'(d_ov), 64'd0);

        // WIDTH=16 random regression
        r_rst = 1'b0;
        m_res = '0;
        m_v = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            r_v   = ($urandom_range(0, 3) != 0);
            r_x   = 16'($urandom);
            r_y   = 16'($urandom);
            r_c   = 1'($urandom);
            r_rst = ($urandom_range(0, 99) == 0);
            tick();
            if (r_rst) begin
                m_res = '0;
                m_v = 1'b0;
            end else begin
                if (r_v) m_res = {1'b0, r_x} + {1'b0, r_y} + 17'(r_c);
                m_v = r_v;
            end
            chk("rnd_sum", 64'(r_s), 64'(m_res[15:0]));
            chk("rnd_cout", 64'(r_co), 64'(m_res[16]));
            chk("rnd_ov", 64'(r_ov), 64'(m_v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name:
full_adder

Overview:
- Clocked WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
- Computes {cout, sum} = x + y + cin and registers the result.
- Default WIDTH=1 gives a registered single-bit full adder.
- Used as a leaf arithmetic primitive in datapaths that need a registered add with carry-in and carry-out.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).
- REG_OUT, 1, 1 = registered outputs with 1-cycle latency; 0 = combinational sum/cout, with out_valid still registered.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies x/y/cin for capture.
- x  input  WIDTH  addend A.
- y  input  WIDTH  addend B.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  (x + y + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- out_valid  output  1  sum/cout hold a result computed from a captured valid input.

Behaviour:
- Clock and reset are fixed as stated:
  - One clock, clk.
  - Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Bit i cell:
  - s[i] = x[i] ^ y[i] ^ c[i]
  - c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]))
  - c[0] = cin; cout = c[WIDTH].
- Arithmetic:
  - Unsigned.
  - Wrap-around modulo 2^WIDTH, with the overflow reported only on cout.
  - No saturation and no signed-overflow flag.
- REG_OUT=1:
  - On a rising edge with rst=0 and in_valid=1: sum <= s, cout <= c[WIDTH], out_valid <= 1.
  - On a rising edge with rst=0 and in_valid=0: sum and cout hold their previous values; out_valid <= 0.
  - Latency is exactly 1 cycle from the capturing edge.
  - Back-to-back valid inputs give one result per cycle; there is no backpressure.
- REG_OUT=0:
  - sum and cout follow the inputs combinationally.
  - out_valid <= in_valid, registered.
- Reset (rst=1 at a rising edge):
  - sum <= 0, cout <= 0, out_valid <= 0 (sum/cout apply in REG_OUT=1 only).
  - Reset takes priority over in_valid.
  - A result captured in the same cycle as reset is discarded.
- Reset asserted mid-stream:
  - Outputs are 0 and out_valid is 0 on the edge after rst is sampled high.
  - The first valid input after rst deasserts produces its result on the following edge.
- X/undriven inputs with in_valid=0 do not change registered outputs.
- No internal state beyond the output registers.

Decomposition:
- Package full_adder_pkg: constant FA_MAX_WIDTH=64, plus a function computing the reference sum/cout for checkers.
- Sub-module fa_cell: purely combinational 1-bit full adder with ports a, b, ci, s, co.
- full_adder instantiates WIDTH fa_cell copies via generate, chained through c[ ], plus the output register stage.

Test Plan:
- WIDTH=1, REG_OUT=1, exhaustive 8 combinations of x,y,cin with in_valid=1 -> one cycle later:
  - sum/cout = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1 for xyc = 000 through 111.
  - out_valid=1 throughout.
- WIDTH=8: x=0xFF, y=0x01, cin=0 -> sum=0x00, cout=1. Then x=0x7F, y=0x80, cin=1 -> sum=0x00, cout=1. Then x=0x12, y=0x34, cin=1 -> sum=0x47, cout=0.
- in_valid hold: valid x=1,y=1,cin=0 (sum=0, cout=1), then in_valid=0 with x=0,y=0,cin=1 for 3 cycles -> sum=0, cout=1 held; out_valid=0.
- Reset mid-stream: rst=1 for 1 cycle while in_valid=1, x=y=cin=1 -> next edge sum=0, cout=0, out_valid=0. With rst=0, the next valid input's result appears 1 cycle later.
- REG_OUT=0, WIDTH=4: x=0xA, y=0x7, cin=1 -> sum=0x2, cout=1 in the same cycle; out_valid rises 1 cycle after in_valid.
- Random regression: 10k random WIDTH=16 vectors with random in_valid -> sum/cout match the package reference function, delayed 1 cycle.
